// File: rtl/mem_arb_pkg.sv
// Shared definitions for the byte-wide memory arbiter: FSM states, port IDs, memory geometry.
package mem_arb_pkg;

  localparam int unsigned MEM_DEPTH  = 2048;
  localparam int unsigned MEM_WIDTH  = 8;
  localparam int unsigned WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHi   = 2'd1,
    StLo   = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic {
    PortIf = 1'b0,
    PortD  = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester pick: round-robin on last grant, or data-first fixed priority when
// MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  clock,
  input  logic  nrst,
  input  logic  req_if,
  input  logic  req_d,
  input  logic  take,
  output port_e gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clock, nrst, take, req_if};

  always_comb begin
    gnt = req_d ? PortD : PortIf;
  end
`else
  port_e last_q;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      last_q <= PortD;
    end else if (take) begin
      last_q <= gnt;
    end
  end

  always_comb begin
    gnt = PortD;
    if (req_if && req_d) begin
      gnt = (last_q == PortD) ? PortIf : PortD;
    end else if (req_if) begin
      gnt = PortIf;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a shared byte-wide memory; each word is two big-endian byte accesses.
// Optional MEM_ARB_FIXED_PRIO_EN selects data-first priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  port_e               port_q;
  port_e               gnt;
  logic                take;
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [WORD_W-1:0]   if_rdata_q, d_rdata_q;

  // Word alignment discards bit 0 of both requester addresses.
  logic unused_addr;
  assign unused_addr = if_addr[0] ^ d_addr[0];

  assign take = (state_q == StIdle) && en && (if_req || d_req);

  rr_arb2 u_arb (
    .clock  (clock),
    .nrst   (nrst),
    .req_if (if_req),
    .req_d  (d_req),
    .take   (take),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = StHi;
      StHi:    state_d = StLo;
      StLo:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      port_q     <= PortIf;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        port_q  <= gnt;
        base_q  <= (gnt == PortIf) ? {if_addr[ADDR_W-1:1], 1'b0} : {d_addr[ADDR_W-1:1], 1'b0};
        we_q    <= (gnt == PortD) && d_we;
        wdata_q <= d_wdata;
      end
      if (state_q == StHi && !we_q) begin
        hi_q <= mem_rdata;
      end
      // Loading the assembled word on the LO->DONE edge makes it coincide with ack.
      if (state_q == StLo && !we_q) begin
        if (port_q == PortIf) begin
          if_rdata_q <= {hi_q, mem_rdata};
        end else begin
          d_rdata_q <= {hi_q, mem_rdata};
        end
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == StHi) begin
      mem_addr = base_q;
      mem_we   = we_q;
      if (we_q) mem_wdata = wdata_q[WORD_W-1:BYTE_W];
    end else if (state_q == StLo) begin
      mem_addr = {base_q[ADDR_W-1:1], 1'b1};
      mem_we   = we_q;
      if (we_q) mem_wdata = wdata_q[BYTE_W-1:0];
    end
  end

  assign if_ack   = (state_q == StDone) && (port_q == PortIf);
  assign d_ack    = (state_q == StDone) && (port_q == PortD);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 2048x8 memory.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        nrst;
  logic        en;
  logic        if_req;
  logic [10:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [10:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [2048];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  mem_arbiter dut (
    .clock     (clock),
    .nrst      (nrst),
    .en        (en),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until the selected ack is seen; n is edges taken, or -1 on timeout.
  task automatic wait_ack(input bit sel_d, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel_d ? d_ack : if_ack) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int nack;
  int kind [4];
  int when [4];
  bit quiet;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    mem[0]     <= 8'h12;
    mem[1]     <= 8'h34;
    mem[11'h021] <= 8'h5A;
    nrst    = 1'b0;
    en      = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    tick();
    tick();
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
    check("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
    check("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    nrst = 1'b1;
    tick();

    // Fetch of word 0: three edges from the sampling edge to the ack cycle.
    if_req  = 1'b1;
    if_addr = 11'h001;
    wait_ack(1'b0, n);
    check("fetch_latency", n, 32'd3);
    check("fetch_rdata", {16'd0, if_rdata}, 32'h1234);
    if_req = 1'b0;
    tick();
    check("fetch_ack_pulse", {31'd0, if_ack}, 32'd0);

    // Data write 0xBEEF to odd address 0x011 lands at 0x010/0x011.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 11'h011;
    d_wdata = 16'hBEEF;
    tick();
    check("wr_hi_addr", {21'd0, mem_addr}, 32'h010);
    check("wr_hi_we", {31'd0, mem_we}, 32'd1);
    check("wr_hi_data", {24'd0, mem_wdata}, 32'hBE);
    d_wdata = 16'h0000;
    tick();
    check("wr_lo_addr", {21'd0, mem_addr}, 32'h011);
    check("wr_lo_data", {24'd0, mem_wdata}, 32'hEF);
    tick();
    check("wr_ack", {31'd0, d_ack}, 32'd1);
    check("wr_d_rdata_kept", {16'd0, d_rdata}, 32'h0000);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("mem_010", {24'd0, mem[11'h010]}, 32'hBE);
    check("mem_011", {24'd0, mem[11'h011]}, 32'hEF);

    // Read back.
    d_req  = 1'b1;
    d_addr = 11'h010;
    wait_ack(1'b1, n);
    check("rd_latency", n, 32'd3);
    check("rd_d_rdata", {16'd0, d_rdata}, 32'hBEEF);
    check("rd_if_rdata_kept", {16'd0, if_rdata}, 32'h1234);
    d_req = 1'b0;
    tick();

    // Both requests held continuously.
    if_req  = 1'b1;
    if_addr = 11'h000;
    d_req   = 1'b1;
    d_addr  = 11'h010;
    nack    = 0;
    for (int t = 1; t <= 40 && nack < 4; t++) begin
      tick();
      if (if_ack || d_ack) begin
        kind[nack] = d_ack ? 1 : 0;
        when[nack] = t;
        nack++;
      end
    end
    check("rr_ack_count", nack, 32'd4);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("rr_kind0", kind[0], 32'd1);
    check("rr_kind1", kind[1], 32'd1);
    check("rr_kind2", kind[2], 32'd1);
    check("rr_kind3", kind[3], 32'd1);
`else
    check("rr_kind0", kind[0], 32'd0);
    check("rr_kind1", kind[1], 32'd1);
    check("rr_kind2", kind[2], 32'd0);
    check("rr_kind3", kind[3], 32'd1);
`endif
    check("rr_first_at", when[0], 32'd3);
    check("rr_gap1", when[1] - when[0], 32'd4);
    check("rr_gap3", when[3] - when[2], 32'd4);
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // Enable low blocks new grants.
    en      = 1'b0;
    if_req  = 1'b1;
    if_addr = 11'h000;
    quiet   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_we || mem_addr != 11'h000 || if_ack || d_ack) quiet = 1'b0;
    end
    check("en_low_quiet", {31'd0, quiet}, 32'd1);
    en = 1'b1;
    wait_ack(1'b0, n);
    check("en_raise_latency", n, 32'd3);
    if_req = 1'b0;
    tick();

    // Enable dropped during HI: the read still completes, then no new grant.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 11'h000;
    tick();
    en = 1'b0;
    wait_ack(1'b1, n);
    check("en_drop_latency", n, 32'd2);
    check("en_drop_rdata", {16'd0, d_rdata}, 32'h1234);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_ack || if_ack || mem_addr != 11'h000) quiet = 1'b0;
    end
    check("en_drop_no_regrant", {31'd0, quiet}, 32'd1);
    d_req = 1'b0;
    en    = 1'b1;
    tick();

    // Reset during LO of a write: only the high byte reaches memory.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 11'h020;
    d_wdata = 16'hA5C3;
    tick();
    tick();
    check("pre_rst_lo_we", {31'd0, mem_we}, 32'd1);
    nrst = 1'b0;
    #1;
    check("async_rst_we", {31'd0, mem_we}, 32'd0);
    check("async_rst_addr", {21'd0, mem_addr}, 32'd0);
    check("async_rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("async_rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("rst_no_ack", {31'd0, d_ack}, 32'd0);
    tick();
    check("mem_020", {24'd0, mem[11'h020]}, 32'hA5);
    check("mem_021", {24'd0, mem[11'h021]}, 32'h5A);
    nrst = 1'b1;
    tick();

    if_req  = 1'b1;
    if_addr = 11'h010;
    wait_ack(1'b0, n);
    check("post_rst_latency", n, 32'd3);
    check("post_rst_rdata", {16'd0, if_rdata}, 32'hBEEF);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared single-port byte-wide program/data memory (2048 x 8). It grants the instruction-fetch port and the data load/store port in turn, performs each 16-bit word access as two consecutive byte accesses (big-endian: high byte at the even address), and returns the assembled word with a one-cycle acknowledge. It sits in `top` between the processor core and the memory instance.

## Interface
- `ADDR_W`, 11, byte address width (2048 bytes)
- `BYTE_W`, 8, memory data width
- `WORD_W`, 16, requester word width
- `clock`  in  1  single clock; all state updates on rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `en`  in  1  arbiter enable; new grants only while high
- `if_req`  in  1  fetch request, level, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch byte address; bit 0 ignored
- `if_rdata`  out  WORD_W  fetched word, valid with `if_ack`, held until next fetch ack
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request, level, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read; stable while `d_req`
- `d_addr`  in  ADDR_W  data byte address; bit 0 ignored
- `d_wdata`  in  WORD_W  write word
- `d_rdata`  out  WORD_W  read word, valid with `d_ack`, held until next data read ack
- `d_ack`  out  1  one-cycle completion pulse for data
- `mem_addr`  out  ADDR_W  memory byte address
- `mem_wdata`  out  BYTE_W  memory write byte
- `mem_we`  out  1  memory write strobe, byte written at rising edge
- `mem_rdata`  in  BYTE_W  memory read byte, combinational from `mem_addr`

## Operation
- FSM: IDLE -> HI -> LO -> DONE -> IDLE.
- IDLE: if `en` and any request, latch winner, its base address `{addr[10:1],0}`, `d_we`/`d_wdata`; go HI. Otherwise stay.
- HI: `mem_addr` = base; read captures `mem_rdata` into word[15:8]; write drives `mem_wdata` = wdata[15:8], `mem_we`=1.
- LO: `mem_addr` = base+1; read captures word[7:0]; write drives wdata[7:0], `mem_we`=1.
- DONE: winner's `ack`=1; for reads the assembled word appears on its `rdata` in the same cycle. Go IDLE.
- Arbitration: 2-way round-robin; simultaneous requests grant the port not granted last; single request always granted. `last_grant` resets to data, so fetch wins the first tie.
- `en` low: no grant in IDLE; an in-flight transaction completes normally.
- Writes leave `d_rdata` unchanged. `if_rdata`/`d_rdata` never change except at own read ack.
- Requester keeping `req` high in the cycle after its ack issues a new transaction with the address/data present then.
- Reset (any state, async): state IDLE, all outputs 0, `last_grant` = data. A write interrupted after HI leaves the high byte written; no recovery.

## Timing
- Request seen high at edge E in IDLE -> HI in E+1, LO in E+2, ack during cycle after E+3 edge; 4 cycles per word, max throughput 1 word / 4 cycles.
- Back-to-back alternating requests: fetch and data each get one word every 8 cycles.
- `mem_addr`, `mem_we`, `mem_wdata` decoded from registered state and latched address only; never from live requester inputs.
- Base 0x7FE accesses 0x7FE, 0x7FF; no wrap possible.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`: defined -> fixed priority, data port always wins simultaneous requests, `last_grant` unused (fetch may starve). Undefined -> round-robin as above.

## Structure
- Shared package/include `mem_arb_pkg`: FSM state encodings (IDLE, HI, LO, DONE), port IDs (PORT_IF, PORT_D), `MEM_DEPTH` 2048, `MEM_WIDTH` 8, `WORD_WIDTH` 16.
- One sub-module `rr_arb2`: 2-request pick with `last_grant` register and fixed-priority bypass under the macro.

## Test plan
- Reset preload 0x0000=0x12, 0x0001=0x34; fetch addr 0x000 -> `if_ack` 4 cycles after request, `if_rdata`=0x1234.
- Data write 0xBEEF to addr 0x011 -> bytes 0x010=0xBE, 0x011=0xEF; read back 0x010 -> `d_rdata`=0xBEEF; `if_rdata` unchanged.
- Both `req` held high continuously -> acks alternate fetch, data, fetch, ... one per 4 cycles; first is fetch. With macro defined -> only data acked.
- `en` low with `if_req` high -> no `mem_*` activity, no ack for 10 cycles; `en` raised -> ack 4 cycles later.
- `en` dropped during HI -> transaction completes, ack delivered, no further grant.
- `nrst` asserted during LO of write 0xA5C3 to 0x020 -> outputs 0 immediately, 0x020=0xA5, 0x021 unchanged, no ack; next request after release served normally.
